// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer arbiter slice.
//   - Stored image geometry, upscale factor, per-bank address and pixel widths
//   - Pixel type, background colour and window limits in screen coordinates
//   - Swap state machine encoding
package vga_fb_pkg;

  localparam int IMG_W       = 160;
  localparam int IMG_H       = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 24;

  typedef logic [DATA_W-1:0] pixel_t;

  localparam pixel_t BG_COLOR = 24'h000000;

  // Image window edges in screen pixels (image size scaled up)
  localparam logic [10:0] H_LIMIT = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0] V_LIMIT = 11'(IMG_H << SCALE_SHIFT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } swap_state_t;

  // Offset of the stored pixel covering screen position (h, v); wraps to ADDR_W bits
  function automatic logic [ADDR_W-1:0] pixel_offset(input logic [10:0] h,
                                                     input logic [10:0] v);
    return ADDR_W'(ADDR_W'(v >> SCALE_SHIFT) * ADDR_W'(IMG_W)
                   + ADDR_W'(h >> SCALE_SHIFT));
  endfunction

endpackage

// File: rtl/vga_fb_swap_fsm.sv
// Double-buffer swap controller.
// A commit request is parked until the next frame start so the displayed bank
// only ever changes between frames.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   swap_req      one-cycle commit request from the host
//   frame_start   one-cycle pulse at the start of each frame
//   state         current state (host writes are only allowed in IDLE)
//   swap_pending  commit requested, not yet applied
//   swap_done     one-cycle pulse in the cycle the new bank is shown
//   front_bank    bank currently displayed
module vga_fb_swap_fsm
  import vga_fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        swap_req,
  input  logic        frame_start,
  output swap_state_t state,
  output logic        swap_pending,
  output logic        swap_done,
  output logic        front_bank
);

  swap_state_t state_next;

  // front_bank flips on the PENDING->SWAP transition so the SWAP cycle already
  // reads from the new bank while swap_done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      front_bank <= 1'b0;
    end else begin
      state <= state_next;
      if (state == PENDING && frame_start) begin
        front_bank <= ~front_bank;
      end
    end
  end

  // A frame_start coinciding with the request is not used; the swap waits
  // for the following frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (swap_req) state_next = PENDING;
      PENDING: if (frame_start) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    swap_pending = (state == PENDING);
    swap_done    = (state == SWAP);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port pixel RAM between VGA scanout reads (front bank)
// and host writes (back bank), and produces the RGB stream for the output stage.
// Scanout always wins; the host is stalled during image-window pixels and
// while a bank swap is pending.
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   de, h_addr, v_addr  timing generator position and active flag
//   frame_start         one-cycle pulse at frame start
//   pix_data, pix_de    RGB pixel and matching de, 3 cycles after the inputs
//   ram_addr/we/wdata   registered RAM command, ram_addr = {bank, offset}
//   ram_rdata           RAM read data, one cycle after ram_addr
//   wr_valid/ready      host write handshake, wr_addr/wr_data payload
//   swap_req            commit the back bank at the next frame start
//   swap_pending, swap_done, front_bank  swap status
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [10:0]       h_addr,
  input  logic [10:0]       v_addr,
  input  logic              frame_start,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_de,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_bank
);

  swap_state_t       swap_state;
  logic              rd_slot;
  logic              wr_accept;
  logic [ADDR_W-1:0] rd_offset;
  logic              slot_d1, slot_d2;
  logic              de_d1, de_d2;

  vga_fb_swap_fsm u_swap_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .state        (swap_state),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_bank   (front_bank)
  );

  assign rd_slot   = de && (h_addr < H_LIMIT) && (v_addr < V_LIMIT);
  assign rd_offset = pixel_offset(h_addr, v_addr);
  assign wr_ready  = !rd_slot && (swap_state == IDLE);
  assign wr_accept = wr_valid && wr_ready;

  // The write bank is fixed when the write is accepted; since accepts only
  // happen in IDLE, a swap in the next cycle cannot redirect it.
  // ram_addr and ram_wdata hold when the RAM is not used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (rd_slot) begin
      ram_addr <= {front_bank, rd_offset};
      ram_we   <= 1'b0;
    end else if (wr_accept) begin
      ram_addr  <= {~front_bank, wr_addr};
      ram_we    <= 1'b1;
      ram_wdata <= wr_data;
    end else begin
      ram_we <= 1'b0;
    end
  end

  // Two-stage delay of slot/de lines them up with ram_rdata; the output
  // register adds the third cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_d1  <= 1'b0;
      slot_d2  <= 1'b0;
      de_d1    <= 1'b0;
      de_d2    <= 1'b0;
      pix_data <= '0;
      pix_de   <= 1'b0;
    end else begin
      slot_d1 <= rd_slot;
      slot_d2 <= slot_d1;
      de_d1   <= de;
      de_d2   <= de_d1;
      pix_de  <= de_d2;
      if (slot_d2) begin
        pix_data <= ram_rdata;
      end else if (de_d2) begin
        pix_data <= BG_COLOR;
      end else begin
        pix_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural
// 1-cycle-read pixel RAM. Inputs change on the falling edge; outputs are
// checked on the falling edge or 1 ns after an input change.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              de;
  logic [10:0]       h_addr;
  logic [10:0]       v_addr;
  logic              frame_start;
  logic [DATA_W-1:0] pix_data;
  logic              pix_de;
  logic [ADDR_W:0]   ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_done;
  logic              front_bank;

  logic              preload_we;
  logic [ADDR_W:0]   preload_addr;
  logic [DATA_W-1:0] preload_data;
  logic [DATA_W-1:0] mem [0:(1<<(ADDR_W+1))-1];

  int total = 0;
  int bad   = 0;

  vga_fb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .de           (de),
    .h_addr       (h_addr),
    .v_addr       (v_addr),
    .frame_start  (frame_start),
    .pix_data     (pix_data),
    .pix_de       (pix_de),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_bank   (front_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM model: registered read, so data follows ram_addr by one cycle
  always @(posedge clk) begin
    if (preload_we) begin
      mem[preload_addr] <= preload_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic apply_stimulus(input logic de_v, input logic [10:0] h_v,
                                input logic [10:0] v_v, input logic wv,
                                input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd,
                                input logic sr, input logic fs);
    de          = de_v;
    h_addr      = h_v;
    v_addr      = v_v;
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    swap_req    = sr;
    frame_start = fs;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    preload_we   = 1'b1;
    preload_addr = {1'b0, 15'd321};
    preload_data = 24'hABCDEF;
    apply_idle();
    repeat (2) @(negedge clk);
    preload_we = 1'b0;
    #1;
    $display("[TB] reset values");
    check_output("rst_pix_data", 32'(pix_data), 32'h0);
    check_output("rst_pix_de", 32'(pix_de), 32'h0);
    check_output("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_output("rst_ram_we", 32'(ram_we), 32'h0);
    check_output("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    check_output("rst_swap_pending", 32'(swap_pending), 32'h0);
    check_output("rst_swap_done", 32'(swap_done), 32'h0);
    check_output("rst_front_bank", 32'(front_bank), 32'h0);
    check_output("rst_wr_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] scanout read h=4 v=8");
    @(negedge clk);
    apply_stimulus(1'b1, 11'd4, 11'd8, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    apply_idle();
    check_output("rd_ram_addr", 32'(ram_addr), 32'h0141);
    check_output("rd_ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_output("rd_pix_data", 32'(pix_data), 32'hABCDEF);
    check_output("rd_pix_de", 32'(pix_de), 32'h1);
    @(negedge clk);
    check_output("blank_pix_data", 32'(pix_data), 32'h0);
    check_output("blank_pix_de", 32'(pix_de), 32'h0);

    $display("[TB] write outside window h=700");
    @(negedge clk);
    apply_stimulus(1'b1, 11'd700, 11'd8, 1'b1, 15'd5, 24'h123456, 1'b0, 1'b0);
    #1;
    check_output("wr_ready_outside", 32'(wr_ready), 32'h1);
    @(negedge clk);
    apply_idle();
    check_output("wr_ram_we", 32'(ram_we), 32'h1);
    check_output("wr_ram_addr", 32'(ram_addr), 32'h8005);
    check_output("wr_ram_wdata", 32'(ram_wdata), 32'h123456);
    @(negedge clk);
    @(negedge clk);
    check_output("bg_pix_data", 32'(pix_data), 32'(BG_COLOR));
    check_output("bg_pix_de", 32'(pix_de), 32'h1);

    $display("[TB] write stalled by read slots");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_ram_we", 32'(ram_we), 32'h0);
      apply_stimulus(1'b1, 11'(4 * i), 11'd0, 1'b1, 15'd7, 24'h0A0B0C, 1'b0, 1'b0);
      #1;
      check_output("stall_wr_ready", 32'(wr_ready), 32'h0);
    end
    @(negedge clk);
    check_output("stall_ram_we_last", 32'(ram_we), 32'h0);
    apply_stimulus(1'b1, 11'd640, 11'd0, 1'b1, 15'd7, 24'h0A0B0C, 1'b0, 1'b0);
    #1;
    check_output("edge_wr_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    apply_idle();
    check_output("late_ram_we", 32'(ram_we), 32'h1);
    check_output("late_ram_addr", 32'(ram_addr), 32'h8007);
    check_output("late_ram_wdata", 32'(ram_wdata), 32'h0A0B0C);

    $display("[TB] swap request mid-frame");
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b1, 15'd9, 24'h55AA55, 1'b0, 1'b0);
    #1;
    check_output("pend_swap_pending", 32'(swap_pending), 32'h1);
    check_output("pend_front_bank", 32'(front_bank), 32'h0);
    check_output("pend_wr_ready", 32'(wr_ready), 32'h0);
    @(negedge clk);
    check_output("pend_ram_we", 32'(ram_we), 32'h0);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b1);
    check_output("pend_hold", 32'(swap_pending), 32'h1);
    @(negedge clk);
    apply_idle();
    #1;
    check_output("swap_front_bank", 32'(front_bank), 32'h1);
    check_output("swap_done_pulse", 32'(swap_done), 32'h1);
    check_output("swap_pending_clr", 32'(swap_pending), 32'h0);
    check_output("swap_wr_ready", 32'(wr_ready), 32'h0);
    @(negedge clk);
    check_output("swap_done_end", 32'(swap_done), 32'h0);
    check_output("swap_front_keep", 32'(front_bank), 32'h1);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b1, 15'd9, 24'h55AA55, 1'b0, 1'b0);
    #1;
    check_output("post_wr_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    apply_stimulus(1'b1, 11'd20, 11'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    check_output("post_ram_addr", 32'(ram_addr), 32'h0009);
    check_output("post_ram_we", 32'(ram_we), 32'h1);
    check_output("post_ram_wdata", 32'(ram_wdata), 32'h55AA55);
    @(negedge clk);
    apply_idle();
    check_output("bank1_rd_addr", 32'(ram_addr), 32'h8005);
    @(negedge clk);
    @(negedge clk);
    check_output("bank1_pix_data", 32'(pix_data), 32'h123456);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    apply_stimulus(1'b1, 11'd700, 11'd8, 1'b1, 15'h7FFF, 24'h0F0F0F, 1'b1, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b1, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    check_output("ovf_ram_addr", 32'(ram_addr), 32'h7FFF);
    check_output("ovf_ram_we", 32'(ram_we), 32'h1);
    check_output("ovf_swap_pending", 32'(swap_pending), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mrst_pix_data", 32'(pix_data), 32'h0);
    check_output("mrst_pix_de", 32'(pix_de), 32'h0);
    check_output("mrst_ram_addr", 32'(ram_addr), 32'h0);
    check_output("mrst_ram_we", 32'(ram_we), 32'h0);
    check_output("mrst_ram_wdata", 32'(ram_wdata), 32'h0);
    check_output("mrst_swap_pending", 32'(swap_pending), 32'h0);
    check_output("mrst_front_bank", 32'(front_bank), 32'h0);
    apply_idle();
    #1;
    check_output("mrst_wr_ready", 32'(wr_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    apply_idle();
    check_output("mrst_fs_pending", 32'(swap_pending), 32'h0);
    check_output("mrst_fs_front", 32'(front_bank), 32'h0);
    check_output("mrst_fs_done", 32'(swap_done), 32'h0);

    $display("[TB] swap_req coincident with frame_start");
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk);
    apply_idle();
    check_output("co_pending", 32'(swap_pending), 32'h1);
    check_output("co_front", 32'(front_bank), 32'h0);
    check_output("co_done", 32'(swap_done), 32'h0);
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    apply_idle();
    check_output("co_swap_front", 32'(front_bank), 32'h1);
    check_output("co_swap_done", 32'(swap_done), 32'h1);

    $display("[TB] frame_start while idle");
    @(negedge clk);
    apply_stimulus(1'b0, 11'd0, 11'd0, 1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    apply_idle();
    check_output("idle_fs_front", 32'(front_bank), 32'h1);
    check_output("idle_fs_pending", 32'(swap_pending), 32'h0);
    check_output("idle_fs_done", 32'(swap_done), 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
